// File: rtl/cpu_param.sv
// cpu_param: parametrised multi-cycle accumulator CPU (A/B registers, N/Z/V flags, NPORTS I/O ports).
// Define CPU_PARAM_CARRY_EN to add the carry flag C and the BRC branch condition.
module cpu_param #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int NPORTS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [AW-1:0]        mem_addr,
    input  logic [DW-1:0]        mem_rdata,
    output logic [DW-1:0]        mem_wdata,
    output logic                 mem_we,
    input  logic [NPORTS*DW-1:0] in_data,
    output logic [NPORTS*DW-1:0] out_data,
    output logic                 halted
);

    typedef enum logic [2:0] {
        FETCH,
        OPERAND,
        MEMORY,
        EXECUTE,
        HALT
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [DW-1:0]       ir_q, ir_d;
    logic [DW-1:0]       mdr_q, mdr_d;
    logic [DW-1:0]       a_q, a_d;
    logic [DW-1:0]       b_q, b_d;
    logic                n_q, n_d;
    logic                z_q, z_d;
    logic                v_q, v_d;
    logic [NPORTS*DW-1:0] out_q, out_d;

    logic [7:0]          op;
    logic                opAlu, opLoad, opStore, opIn, opOut, opBranch, opHalt;
    logic [1:0]          pp;
    logic [DW-1:0]       rSel;
    logic [DW-1:0]       inVal;
    logic [DW:0]         sum, diff;
    logic [DW-1:0]       aluRes;
    logic                aluV;
    logic                taken;
    logic                regWe;
    logic [DW-1:0]       regVal;

    // LOAD, STORE and branches carry an operand word and take four cycles
    function automatic logic isFourPhase(input logic [7:0] code);
        return (code[7:2] == 6'b000000) || (code[7:3] == 5'b00100);
    endfunction

    assign op       = ir_q[7:0];
    assign opAlu    = op[7] && (op[3:1] == 3'b000);
    assign opLoad   = (op[7:1] == 7'b0000000);
    assign opStore  = (op[7:1] == 7'b0000001);
    assign opIn     = (op[7:3] == 5'b00010);
    assign opOut    = (op[7:3] == 5'b00011);
    assign opBranch = (op[7:3] == 5'b00100);
    assign opHalt   = (op == 8'h30);
    assign pp       = op[2:1];
    assign rSel     = op[0] ? b_q : a_q;

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    // Overflow is carry-into-MSB xor carry-out, which also works for borrow on SUB
    always_comb begin
        aluRes = '0;
        aluV   = 1'b0;
        case (op[6:4])
            3'b000: begin
                aluRes = sum[DW-1:0];
                aluV   = a_q[DW-1] ^ b_q[DW-1] ^ sum[DW-1] ^ sum[DW];
            end
            3'b001: begin
                aluRes = diff[DW-1:0];
                aluV   = a_q[DW-1] ^ b_q[DW-1] ^ diff[DW-1] ^ diff[DW];
            end
            3'b010: aluRes = rSel << 1;
            3'b011: aluRes = rSel >> 1;
            3'b100: aluRes = a_q ^ b_q;
            3'b101: aluRes = ~rSel;
            3'b110: begin
                aluRes = '0 - rSel;
                aluV   = (rSel == {1'b1, {(DW-1){1'b0}}});
            end
            default: aluRes = '0;
        endcase
    end

`ifdef CPU_PARAM_CARRY_EN
    logic aluC;
    logic c_q, c_d;

    always_comb begin
        case (op[6:4])
            3'b000:  aluC = sum[DW];
            3'b001:  aluC = diff[DW];
            3'b010:  aluC = rSel[DW-1];
            3'b011:  aluC = rSel[0];
            default: aluC = 1'b0;
        endcase
    end
`endif

    always_comb begin
        case (op[2:0])
            3'b000:  taken = 1'b1;
            3'b001:  taken = z_q;
            3'b010:  taken = n_q;
            3'b011:  taken = v_q;
            3'b100:  taken = !z_q;
`ifdef CPU_PARAM_CARRY_EN
            3'b101:  taken = c_q;
`endif
            default: taken = 1'b0;
        endcase
    end

    // Ports beyond NPORTS read as zero
    always_comb begin
        inVal = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (pp == 2'(p)) inVal = in_data[p*DW +: DW];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        z_d     = z_q;
        v_d     = v_q;
        out_d   = out_q;
`ifdef CPU_PARAM_CARRY_EN
        c_d     = c_q;
`endif
        regWe   = 1'b0;
        regVal  = '0;
        case (state_q)
            FETCH: begin
                ir_d = mem_rdata;
                if (isFourPhase(mem_rdata[7:0])) begin
                    pc_d    = pc_q + AW'(1);
                    state_d = OPERAND;
                end else begin
                    state_d = EXECUTE;
                end
            end
            OPERAND: begin
                mdr_d   = mem_rdata;
                state_d = MEMORY;
            end
            MEMORY: state_d = EXECUTE;
            EXECUTE: begin
                pc_d    = pc_q + AW'(1);
                state_d = FETCH;
                if (opAlu) begin
                    regWe  = 1'b1;
                    regVal = aluRes;
                    n_d    = aluRes[DW-1];
                    z_d    = (aluRes == '0);
                    v_d    = aluV;
`ifdef CPU_PARAM_CARRY_EN
                    c_d    = aluC;
`endif
                end
                if (opLoad) begin
                    regWe  = 1'b1;
                    regVal = mem_rdata;
                end
                if (opIn) begin
                    regWe  = 1'b1;
                    regVal = inVal;
                end
                if (opOut) begin
                    for (int p = 0; p < NPORTS; p++) begin
                        if (pp == 2'(p)) out_d[p*DW +: DW] = rSel;
                    end
                end
                if (opBranch && taken) pc_d = mdr_q[AW-1:0];
                if (opHalt) state_d = HALT;
                if (regWe) begin
                    if (op[0]) b_d = regVal;
                    else       a_d = regVal;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            out_q   <= '0;
`ifdef CPU_PARAM_CARRY_EN
            c_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            z_q     <= z_d;
            v_q     <= v_d;
            out_q   <= out_d;
`ifdef CPU_PARAM_CARRY_EN
            c_q     <= c_d;
`endif
        end
    end

    // The operand address is only driven while a 4-phase instruction needs it
    assign mem_addr  = ((state_q == MEMORY) || ((state_q == EXECUTE) && isFourPhase(op)))
                       ? mdr_q[AW-1:0] : pc_q;
    assign mem_we    = (state_q == MEMORY) && opStore;
    assign mem_wdata = rSel;
    assign out_data  = out_q;
    assign halted    = (state_q == HALT);

endmodule
